// File: rtl/bank_byte_access_ctrl_if.sv
// Request/response and bank-side signal bundle for the byte access controller.
// The controller connects through the slave modport; clients and the bank model
// together form the master side.
interface bank_byte_access_ctrl_if #(
    parameter int AW = 8
);
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [1:0]      req_we;
    logic [2*AW-1:0] req_addr;
    logic [3:0]      req_sel;
    logic [15:0]     req_wdata;
    logic [1:0]      rsp_valid;
    logic [7:0]      rsp_rdata;
    logic            busy;
    logic            bank_en;
    logic            bank_we;
    logic [AW-1:0]   bank_addr;
    logic [31:0]     bank_wdata;
    logic [31:0]     bank_rdata;

    modport slave (
        input  req_valid, req_we, req_addr, req_sel, req_wdata, bank_rdata,
        output req_ready, rsp_valid, rsp_rdata, busy,
               bank_en, bank_we, bank_addr, bank_wdata
    );

    modport master (
        output req_valid, req_we, req_addr, req_sel, req_wdata, bank_rdata,
        input  req_ready, rsp_valid, rsp_rdata, busy,
               bank_en, bank_we, bank_addr, bank_wdata
    );
endinterface

// File: rtl/bank_byte_access_ctrl.sv
// Byte-granular access controller for a 32-bit word bank without byte enables.
// Two requesters share the bank round-robin; byte reads extract a lane from the
// word, byte writes read the word, merge the new byte and write the word back.
// Only one access is in flight; a response strobe closes every access.
module bank_byte_access_ctrl #(
    parameter int AW = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    bank_byte_access_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_CAP,
        ST_WR,
        ST_RSP
    } state_t;

    state_t         r_state;
    state_t         w_next_state;
    logic           r_last_grant;
    logic           r_cap_we;
    logic           r_cap_id;
    logic [AW-1:0]  r_cap_addr;
    logic [1:0]     r_cap_sel;
    logic [7:0]     r_cap_wdata;
    logic [31:0]    r_word;
    logic [7:0]     r_old;

    logic           w_accept;
    logic           w_grant_id;
    logic [7:0]     w_lane;
    logic [31:0]    w_merged;

    // Pick the requester to serve: a sole requester wins, contention alternates.
    always_comb begin
        w_accept   = 1'b0;
        w_grant_id = 1'b0;
        if (r_state == ST_IDLE && rst_n) begin
            case (bus.req_valid)
                2'b01: begin
                    w_accept   = 1'b1;
                    w_grant_id = 1'b0;
                end
                2'b10: begin
                    w_accept   = 1'b1;
                    w_grant_id = 1'b1;
                end
                2'b11: begin
                    w_accept   = 1'b1;
                    w_grant_id = ~r_last_grant;
                end
                default: begin
                    w_accept   = 1'b0;
                    w_grant_id = 1'b0;
                end
            endcase
        end
    end

    // Extract the addressed lane from the bank word and build the merged write word.
    always_comb begin
        w_lane   = bus.bank_rdata[{r_cap_sel, 3'b000} +: 8];
        w_merged = r_word;
        w_merged[{r_cap_sel, 3'b000} +: 8] = r_cap_wdata;
    end

    // Sequence one access: read strobe, capture, optional write-back, response.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next_state = ST_RD;
            ST_RD:   w_next_state = ST_CAP;
            ST_CAP:  w_next_state = r_cap_we ? ST_WR : ST_RSP;
            ST_WR:   w_next_state = ST_RSP;
            ST_RSP:  w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State register; reset aborts any access in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Latch the winning request and remember who was served for round-robin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
            r_cap_we     <= 1'b0;
            r_cap_id     <= 1'b0;
            r_cap_addr   <= '0;
            r_cap_sel    <= '0;
            r_cap_wdata  <= '0;
        end else if (w_accept) begin
            r_last_grant <= w_grant_id;
            r_cap_id     <= w_grant_id;
            r_cap_we     <= bus.req_we[w_grant_id];
            r_cap_addr   <= w_grant_id ? bus.req_addr[2*AW-1:AW] : bus.req_addr[AW-1:0];
            r_cap_sel    <= w_grant_id ? bus.req_sel[3:2]        : bus.req_sel[1:0];
            r_cap_wdata  <= w_grant_id ? bus.req_wdata[15:8]     : bus.req_wdata[7:0];
        end
    end

    // Hold the bank word and the old byte returned with the response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word <= '0;
            r_old  <= '0;
        end else if (r_state == ST_CAP) begin
            r_word <= bus.bank_rdata;
            r_old  <= w_lane;
        end
    end

    // Decode bank, handshake and response outputs from the state; idle values are zero.
    always_comb begin
        bus.req_ready  = 2'b00;
        bus.rsp_valid  = 2'b00;
        bus.rsp_rdata  = 8'h00;
        bus.busy       = (r_state != ST_IDLE);
        bus.bank_en    = 1'b0;
        bus.bank_we    = 1'b0;
        bus.bank_addr  = '0;
        bus.bank_wdata = 32'h0;
        if (w_accept) begin
            bus.req_ready = w_grant_id ? 2'b10 : 2'b01;
        end
        case (r_state)
            ST_RD: begin
                bus.bank_en   = 1'b1;
                bus.bank_addr = r_cap_addr;
            end
            ST_WR: begin
                bus.bank_en    = 1'b1;
                bus.bank_we    = 1'b1;
                bus.bank_addr  = r_cap_addr;
                bus.bank_wdata = w_merged;
            end
            ST_RSP: begin
                bus.rsp_valid = r_cap_id ? 2'b10 : 2'b01;
                bus.rsp_rdata = r_old;
            end
            default: begin
                bus.bank_en = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_bank_byte_access_ctrl.sv
// Bench for the byte access controller: directed scenarios with literal expected
// values, then randomized traffic against a transaction-level reference model.
module tb_bank_byte_access_ctrl;

    localparam int AW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    bank_byte_access_ctrl_if #(.AW(AW)) busIf ();

    bank_byte_access_ctrl #(.AW(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busIf.slave)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    logic [31:0] bankMem [256];
    logic        memClr = 1'b0;
    logic        preEn = 1'b0;
    logic [7:0]  preAddr = 8'h00;
    logic [31:0] preData = 32'h0;

    int checkCount = 0;
    int passCount  = 0;
    int grantQ[$];

    // Word bank model: one-cycle read latency, writes on the strobe edge, plus bench preload.
    always @(posedge clk) begin
        if (memClr) begin
            for (int i = 0; i < 256; i++) bankMem[i] <= 32'h0;
        end else if (preEn) begin
            bankMem[preAddr] <= preData;
        end else if (busIf.bank_en) begin
            if (busIf.bank_we) bankMem[busIf.bank_addr] <= busIf.bank_wdata;
            else               busIf.bank_rdata <= bankMem[busIf.bank_addr];
        end
    end

    // Count one comparison and report it when observed and expected differ.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        if (obs === exp) passCount++;
        else $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic clearReq();
        busIf.req_valid = 2'b00;
        busIf.req_we    = 2'b00;
        busIf.req_addr  = '0;
        busIf.req_sel   = 4'h0;
        busIf.req_wdata = 16'h0;
    endtask

    task automatic driveReq(input int id, input bit v, input bit we, input logic [7:0] addr,
                            input logic [1:0] sel, input logic [7:0] wd);
        busIf.req_valid[id]          = v;
        busIf.req_we[id]             = we;
        busIf.req_addr[id*AW +: AW]  = addr;
        busIf.req_sel[id*2 +: 2]     = sel;
        busIf.req_wdata[id*8 +: 8]   = wd;
    endtask

    task automatic preload(input logic [7:0] addr, input logic [31:0] data);
        preAddr = addr;
        preData = data;
        preEn   = 1'b1;
        @(negedge clk);
        preEn   = 1'b0;
    endtask

    // One isolated access from an idle controller, checked cycle by cycle.
    task automatic applyStimulus(input int id, input bit we, input logic [7:0] addr,
                                 input logic [1:0] sel, input logic [7:0] wd,
                                 input logic [7:0] expOld, input logic [31:0] expWord);
        clearReq();
        driveReq(id, 1'b1, we, addr, sel, wd);
        #1;
        checkOutput("accept_ready", busIf.req_ready, (id == 0) ? 2'b01 : 2'b10);
        @(negedge clk);
        busIf.req_valid = 2'b00;
        #1;
        checkOutput("rd_strobe", {busIf.bank_en, busIf.bank_we, busIf.bank_addr}, {1'b1, 1'b0, addr});
        checkOutput("busy_rd", busIf.busy, 1'b1);
        @(negedge clk);
        #1;
        checkOutput("cap_no_strobe", {busIf.bank_en, busIf.rsp_valid}, 3'b000);
        if (we) begin
            @(negedge clk);
            #1;
            checkOutput("wr_strobe", {busIf.bank_en, busIf.bank_we, busIf.bank_addr}, {1'b1, 1'b1, addr});
            checkOutput("wr_word", busIf.bank_wdata, expWord);
            checkOutput("wr_no_rsp", busIf.rsp_valid, 2'b00);
        end
        @(negedge clk);
        #1;
        checkOutput("rsp_valid", busIf.rsp_valid, (id == 0) ? 2'b01 : 2'b10);
        checkOutput("rsp_rdata", busIf.rsp_rdata, expOld);
        @(negedge clk);
        #1;
        checkOutput("rsp_done", {busIf.rsp_valid, busIf.busy, busIf.bank_en}, 4'h0);
    endtask

    // Random traffic against a transaction model: each accepted request is served
    // atomically on a model memory, with fixed response timing per access type.
    task automatic runRandom(input int nStim, input bit holdBoth);
        logic [31:0] modelMem [256];
        bit          rqValid [2];
        bit          rqWe [2];
        logic [7:0]  rqAddr [2];
        logic [1:0]  rqSel [2];
        logic [7:0]  rqData [2];
        int          rqDelay [2];
        int          rdCyc = -100;
        int          wrCyc = -100;
        int          rspCyc = -100;
        int          freeCyc = 0;
        int          g = 0;
        bit          lastGrant = 1'b1;
        bit          idle;
        bit          strobe;
        logic [1:0]  expReady;
        logic [1:0]  expId = 2'b00;
        logic [7:0]  expAddr = 8'h00;
        logic [7:0]  expOld = 8'h00;
        logic [31:0] expWord = 32'h0;
        for (int i = 0; i < 256; i++) modelMem[i] = bankMem[i];
        for (int r = 0; r < 2; r++) begin
            rqValid[r] = 1'b0;
            rqDelay[r] = 0;
        end
        for (int cyc = 0; cyc < nStim + 8; cyc++) begin
            for (int r = 0; r < 2; r++) begin
                if (cyc >= nStim) begin
                    rqValid[r] = 1'b0;
                end else if (!rqValid[r]) begin
                    if (rqDelay[r] > 0) begin
                        rqDelay[r]--;
                    end else begin
                        rqValid[r] = 1'b1;
                        rqWe[r]    = 1'($urandom_range(0, 1));
                        rqAddr[r]  = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 7));
                        rqSel[r]   = 2'($urandom_range(0, 3));
                        rqData[r]  = 8'($urandom_range(0, 255));
                    end
                end else if (!holdBoth && $urandom_range(0, 15) == 0) begin
                    rqValid[r] = 1'b0;
                    rqDelay[r] = $urandom_range(1, 3);
                end
                driveReq(r, rqValid[r], rqWe[r], rqAddr[r], rqSel[r], rqData[r]);
            end
            #1;
            idle     = (cyc >= freeCyc);
            expReady = 2'b00;
            if (idle && (rqValid[0] || rqValid[1])) begin
                if (rqValid[0] && rqValid[1]) g = lastGrant ? 0 : 1;
                else if (rqValid[0])          g = 0;
                else                          g = 1;
                expReady = (g == 0) ? 2'b01 : 2'b10;
            end
            strobe = (cyc == rdCyc) || (cyc == wrCyc);
            checkOutput("rnd_ready", busIf.req_ready, expReady);
            checkOutput("rnd_busy", busIf.busy, !idle);
            checkOutput("rnd_bank_en", busIf.bank_en, strobe);
            checkOutput("rnd_bank_we", busIf.bank_we, cyc == wrCyc);
            if (strobe) checkOutput("rnd_bank_addr", busIf.bank_addr, expAddr);
            else        checkOutput("rnd_bank_idle", {busIf.bank_addr, busIf.bank_wdata}, 40'h0);
            if (cyc == wrCyc) checkOutput("rnd_wdata", busIf.bank_wdata, expWord);
            checkOutput("rnd_rsp_valid", busIf.rsp_valid, (cyc == rspCyc) ? expId : 2'b00);
            checkOutput("rnd_rsp_rdata", busIf.rsp_rdata, (cyc == rspCyc) ? expOld : 8'h00);
            if (expReady != 2'b00) begin
                expAddr = rqAddr[g];
                expId   = expReady;
                expOld  = 8'(modelMem[expAddr] >> (8 * int'(rqSel[g])));
                if (rqWe[g]) begin
                    expWord = (modelMem[expAddr] & ~(32'hFF << (8 * int'(rqSel[g]))))
                            | (32'(rqData[g]) << (8 * int'(rqSel[g])));
                    modelMem[expAddr] = expWord;
                end
                rdCyc   = cyc + 1;
                wrCyc   = rqWe[g] ? cyc + 3 : -100;
                rspCyc  = cyc + (rqWe[g] ? 4 : 3);
                freeCyc = cyc + (rqWe[g] ? 5 : 4);
                lastGrant  = (g == 1);
                rqValid[g] = 1'b0;
                rqDelay[g] = holdBoth ? 0 : $urandom_range(0, 3);
                if (holdBoth) grantQ.push_back(g);
            end
            @(negedge clk);
        end
        for (int a = 0; a < 8; a++) checkOutput("rnd_mem", bankMem[a], modelMem[a]);
        checkOutput("rnd_mem_top", bankMem[255], modelMem[255]);
    endtask

    // Directed scenarios, contention from reset, then random traffic.
    initial begin
        clearReq();
        rst_n  = 1'b0;
        memClr = 1'b1;
        @(negedge clk);
        memClr = 1'b0;
        busIf.req_valid = 2'b11;
        #1;
        checkOutput("reset_outputs",
                    {busIf.req_ready, busIf.rsp_valid, busIf.rsp_rdata, busIf.busy,
                     busIf.bank_en, busIf.bank_we, busIf.bank_addr}, 23'h0);
        checkOutput("reset_wdata", busIf.bank_wdata, 32'h0);
        busIf.req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            checkOutput("idle_quiet", {busIf.req_ready, busIf.busy, busIf.bank_en}, 4'h0);
        end

        preload(8'd5, 32'hA1B2C3D4);
        applyStimulus(0, 1'b0, 8'd5, 2'd2, 8'h00, 8'hB2, 32'h0);
        applyStimulus(1, 1'b1, 8'd5, 2'd0, 8'h55, 8'hD4, 32'hA1B2C355);
        checkOutput("write_mem", bankMem[5], 32'hA1B2C355);

        preload(8'd9, 32'h0);
        applyStimulus(0, 1'b1, 8'd9, 2'd3, 8'h11, 8'h00, 32'h11000000);
        applyStimulus(1, 1'b1, 8'd9, 2'd1, 8'h22, 8'h00, 32'h11002200);
        checkOutput("rmw_mem", bankMem[9], 32'h11002200);

        preload(8'd3, 32'hDEADBEEF);
        clearReq();
        driveReq(0, 1'b1, 1'b1, 8'd3, 2'd1, 8'h77);
        #1;
        checkOutput("abort_accept", busIf.req_ready, 2'b01);
        @(negedge clk);
        busIf.req_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
        #1;
        checkOutput("abort_in_wr", {busIf.bank_en, busIf.bank_we}, 2'b11);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_drop", {busIf.bank_en, busIf.busy, busIf.rsp_valid}, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            checkOutput("abort_no_rsp", {busIf.rsp_valid, busIf.busy}, 3'h0);
        end
        checkOutput("abort_mem_kept", bankMem[3], 32'hDEADBEEF);
        applyStimulus(0, 1'b0, 8'd3, 2'd1, 8'h00, 8'hBE, 32'h0);

        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        grantQ.delete();
        runRandom(60, 1'b1);
        for (int k = 0; k < 4; k++) begin
            checkOutput("contend_order", (grantQ.size() > k) ? grantQ[k] : 7, k % 2);
        end

        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        runRandom(600, 1'b0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
